// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the ASCII register-access command engine:
// character constants, parser states and hex conversion helpers.
package uart_cmd_pkg;

  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_W  = 8'h57;
  localparam logic [7:0] ASC_R  = 8'h52;
  localparam logic [7:0] ASC_K  = 8'h4B;
  localparam logic [7:0] ASC_E  = 8'h45;

  typedef enum logic [2:0] {
    S_CMD,
    S_HEX,
    S_EOL,
    S_DISCARD,
    S_EXEC,
    S_RDCAP,
    S_RESP
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_nib_t;

  function automatic hex_nib_t hex2nib(input logic [7:0] c);
    hex_nib_t r;
    r.valid = 1'b1;
    if (c >= 8'h30 && c <= 8'h39)      r.nib = c[3:0];
    else if (c >= 8'h41 && c <= 8'h46) r.nib = c[3:0] + 4'd9;
    else if (c >= 8'h61 && c <= 8'h66) r.nib = c[3:0] + 4'd9;
    else begin
      r.valid = 1'b0;
      r.nib   = 4'h0;
    end
    return r;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  // Matches an uppercase command letter or its lowercase twin.
  function automatic logic is_letter(input logic [7:0] c, input logic [7:0] upper);
    return (c == upper) || (c == (upper | 8'h20));
  endfunction

endpackage

// File: rtl/uart_reg_cmd.sv
// Parses W/R hex commands from the UART RX FIFO, performs one register
// access per line and pushes an ASCII reply into the TX FIFO.
module uart_reg_cmd
  import uart_cmd_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 27000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       pop_rx,
  output logic [7:0] tx_data,
  input  logic       tx_full,
  output logic       push_tx,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  state_t          r_state;
  logic            r_is_wr;
  logic [15:0]     r_acc;
  logic [2:0]      r_cnt;
  logic [2:0]      r_need;
  logic [3:0][7:0] r_buf;
  logic [2:0]      r_len;
  logic [2:0]      r_idx;
  logic [31:0]     r_tmo;

  hex_nib_t w_hex;
  logic     w_accept;
  logic     w_take;
  logic     w_tmo_hit;

  assign w_hex     = hex2nib(rx_data);
  assign w_accept  = (r_state == S_CMD) || (r_state == S_HEX) ||
                     (r_state == S_EOL) || (r_state == S_DISCARD);
  // The pop_rx term leaves a dead cycle after each pop so the FIFO flags settle.
  assign w_take    = w_accept && !rx_empty && !pop_rx;
  assign w_tmo_hit = (IDLE_TIMEOUT != 0) && (r_tmo == IDLE_TIMEOUT);
  assign busy      = (r_state != S_CMD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CMD;
      r_is_wr   <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_need    <= '0;
      // NOTE: the reply buffer is a small register bank, so it is reset like any other flop.
      r_buf     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_tmo     <= '0;
      pop_rx    <= 1'b0;
      push_tx   <= 1'b0;
      tx_data   <= 8'h00;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle and are raised below only where needed,
      // which keeps them single-cycle and avoids any path where they hold a value.
      pop_rx  <= 1'b0;
      push_tx <= 1'b0;
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;

      if (w_take || r_state == S_CMD) r_tmo <= '0;
      else if (w_accept)              r_tmo <= r_tmo + 32'd1;

      case (r_state)
        S_CMD: begin
          if (w_take) begin
            pop_rx <= 1'b1;
            if (is_letter(rx_data, ASC_W)) begin
              r_state <= S_HEX;
              r_need  <= 3'd4;
              r_is_wr <= 1'b1;
              r_acc   <= '0;
              r_cnt   <= '0;
            end else if (is_letter(rx_data, ASC_R)) begin
              r_state <= S_HEX;
              r_need  <= 3'd2;
              r_is_wr <= 1'b0;
              r_acc   <= '0;
              r_cnt   <= '0;
            end else if (rx_data != ASC_CR && rx_data != ASC_LF && rx_data != ASC_SP) begin
              r_state <= S_DISCARD;
            end
          end
        end

        S_HEX, S_EOL, S_DISCARD: begin
          if (w_take) begin
            pop_rx <= 1'b1;
            if (r_state == S_HEX && w_hex.valid) begin
              r_acc <= {r_acc[11:0], w_hex.nib};
              r_cnt <= r_cnt + 3'd1;
              if (r_cnt + 3'd1 == r_need) r_state <= S_EOL;
            end else if (rx_data == ASC_CR) begin
              if (r_state == S_EOL) begin
                r_state <= S_EXEC;
              end else begin
                r_buf   <= {8'h00, ASC_LF, ASC_CR, ASC_E};
                r_len   <= 3'd3;
                r_idx   <= 3'd0;
                r_state <= S_RESP;
              end
            end else begin
              r_state <= S_DISCARD;
            end
          end else if (w_tmo_hit) begin
            // Stale partial line: drop it without a reply.
            r_state <= S_CMD;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end

        S_EXEC: begin
          if (r_is_wr) begin
            reg_addr  <= r_acc[15:8];
            reg_wdata <= r_acc[7:0];
            reg_we    <= 1'b1;
            r_buf     <= {8'h00, ASC_LF, ASC_CR, ASC_K};
            r_len     <= 3'd3;
            r_idx     <= 3'd0;
            r_state   <= S_RESP;
          end else begin
            reg_addr <= r_acc[7:0];
            reg_re   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_RDCAP;
          end
        end

        S_RDCAP: begin
          // First cycle waits for the bus to return data; the second captures it
          // and launches the first reply byte straight away when the FIFO has room.
          if (r_cnt == 3'd0) begin
            r_cnt <= 3'd1;
          end else begin
            r_buf   <= {ASC_LF, ASC_CR, nib2hex(reg_rdata[3:0]), nib2hex(reg_rdata[7:4])};
            r_len   <= 3'd4;
            r_state <= S_RESP;
            if (!tx_full) begin
              tx_data <= nib2hex(reg_rdata[7:4]);
              push_tx <= 1'b1;
              r_idx   <= 3'd1;
            end else begin
              r_idx   <= 3'd0;
            end
          end
        end

        S_RESP: begin
          if (!push_tx && !tx_full) begin
            tx_data <= r_buf[r_idx[1:0]];
            push_tx <= 1'b1;
            r_idx   <= r_idx + 3'd1;
            if (r_idx + 3'd1 == r_len) r_state <= S_CMD;
          end
        end

        default: r_state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_cmd.sv
// Scoreboard bench for uart_reg_cmd: a line-level reference model queues
// expected register accesses and reply bytes; a monitor checks the DUT.
module tb_uart_reg_cmd;

  localparam int unsigned TMO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       pop_rx;
  logic [7:0] tx_data;
  logic       tx_full = 1'b0;
  logic       push_tx;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;

  uart_reg_cmd #(.IDLE_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .pop_rx    (pop_rx),
    .tx_data   (tx_data),
    .tx_full   (tx_full),
    .push_tx   (push_tx),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  byte unsigned rx_q[$];
  logic [7:0]   exp_tx[$];
  acc_t         exp_acc[$];
  logic [7:0]   bus_mem[256];
  logic [7:0]   ref_mem[256];
  int           n_checks = 0;
  int           n_pass = 0;
  int           n_push = 0;
  bit           rand_full = 1'b0;
  bit           force_full = 1'b0;
  logic         full_q = 1'b0;
  logic         prev_we = 1'b0;
  logic         prev_re = 1'b0;
  logic         prev_push = 1'b0;
  acc_t         mon_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // RX FIFO model: flags settle at the falling edge, pops land on the rising edge.
  always @(negedge clk) begin
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  end

  always @(posedge clk) begin
    if (pop_rx && rx_q.size() > 0) void'(rx_q.pop_front());
    full_q = tx_full;
  end

  // Register bus model with one cycle of read latency.
  always @(posedge clk) begin
    if (reg_we) bus_mem[reg_addr] = reg_wdata;
    if (reg_re) reg_rdata <= bus_mem[reg_addr];
  end

  always @(negedge clk) tx_full = rand_full ? ($urandom_range(0, 3) == 0) : force_full;

  // Monitor: compares every push and every register strobe against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (push_tx) begin
        n_push++;
        check("push_when_full", 32'(full_q), 32'd0);
        if (prev_push) check("push_back_to_back", 32'(prev_push), 32'd0);
        if (exp_tx.size() == 0) check("tx_extra", {24'd0, tx_data}, 32'h100);
        else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
      end
      if (reg_we && reg_re) check("we_re_exclusive", 32'({reg_we, reg_re}), 32'd0);
      if ((reg_we && prev_we) || (reg_re && prev_re)) check("strobe_width", 32'd2, 32'd1);
      if (reg_we || reg_re) begin
        if (exp_acc.size() == 0) begin
          check("acc_extra", {24'd0, reg_addr}, 32'h100);
        end else begin
          mon_a = exp_acc.pop_front();
          check("acc_kind", 32'(reg_we), 32'(mon_a.wr));
          check("acc_addr", {24'd0, reg_addr}, {24'd0, mon_a.addr});
          if (mon_a.wr) check("acc_wdata", {24'd0, reg_wdata}, {24'd0, mon_a.data});
        end
      end
    end
    prev_we   = reg_we;
    prev_re   = reg_re;
    prev_push = push_tx;
  end

  function automatic int hexval(input byte unsigned c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  task automatic push_eol();
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h0A);
  endtask

  // Reference: decide the outcome of a whole line from the command grammar.
  task automatic model_line(input byte unsigned b[$]);
    int         i, n, h;
    int         v;
    logic [7:0] d;
    bit         ok;
    string      hx;
    hx = "0123456789ABCDEF";
    i = 0;
    v = 0;
    while (i < b.size() && b[i] == 8'h20) i++;
    if (i == b.size()) return;
    if (b[i] == 8'h57 || b[i] == 8'h77) n = 4;
    else if (b[i] == 8'h52 || b[i] == 8'h72) n = 2;
    else n = 0;
    ok = (n != 0) && (b.size() - i - 1 == n);
    for (int j = i + 1; j < b.size(); j++) begin
      h = hexval(b[j]);
      if (h < 0) ok = 1'b0;
      else v = v * 16 + h;
    end
    if (!ok) begin
      exp_tx.push_back(8'h45);
      push_eol();
    end else if (n == 4) begin
      exp_acc.push_back('{wr: 1'b1, addr: 8'(v / 256), data: 8'(v % 256)});
      ref_mem[v / 256] = 8'(v % 256);
      exp_tx.push_back(8'h4B);
      push_eol();
    end else begin
      d = ref_mem[v];
      exp_acc.push_back('{wr: 1'b0, addr: 8'(v), data: 8'h00});
      exp_tx.push_back(hx[d / 16]);
      exp_tx.push_back(hx[d % 16]);
      push_eol();
    end
  endtask

  task automatic send_q(input byte unsigned b[$], input bit lf);
    model_line(b);
    foreach (b[i]) rx_q.push_back(b[i]);
    rx_q.push_back(8'h0D);
    if (lf) rx_q.push_back(8'h0A);
  endtask

  task automatic send_line(input string s, input bit lf);
    byte unsigned b[$];
    for (int i = 0; i < s.len(); i++) b.push_back(s[i]);
    send_q(b, lf);
  endtask

  task automatic rand_body(output byte unsigned b[$]);
    string hexs, alpha;
    int    kind, n;
    hexs  = "0123456789abcdefABCDEF";
    alpha = "WwRr0123456789abcdefABCDEFGgxZ- :";
    b = {};
    kind = $urandom_range(0, 3);
    if ($urandom_range(0, 5) == 0) b.push_back(8'h20);
    if (kind == 0) begin
      b.push_back($urandom_range(0, 1) ? 8'h57 : 8'h77);
      repeat (4) b.push_back(hexs[$urandom_range(0, 21)]);
    end else if (kind == 1) begin
      b.push_back($urandom_range(0, 1) ? 8'h52 : 8'h72);
      repeat (2) b.push_back(hexs[$urandom_range(0, 21)]);
    end else begin
      n = $urandom_range(0, 6);
      repeat (n) b.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(exp_tx.size() == 0 && exp_acc.size() == 0 &&
                           rx_q.size() == 0 && !busy)) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, 32'(k < budget), 32'd1);
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_pop_rx", 32'(pop_rx), 32'd0);
    check("rst_push_tx", 32'(push_tx), 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_reg_re", 32'(reg_re), 32'd0);
    check("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
    check("rst_reg_wdata", {24'd0, reg_wdata}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            base, k;
    byte unsigned  b[$];
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'((i * 37 + 11) % 256);
      ref_mem[i] = 8'((i * 37 + 11) % 256);
    end
    bus_mem[8'h3C] = 8'h7E;
    ref_mem[8'h3C] = 8'h7E;

    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // Read reply stalled by a full TX FIFO while a write waits behind it.
    force_full = 1'b1;
    base = n_push;
    send_line("r3c", 1'b0);
    send_line("W3CA5", 1'b0);
    repeat (100) @(negedge clk);
    #1;
    check("full_no_push", n_push - base, 32'd0);
    check("full_rx_held", rx_q.size(), 32'd6);
    check("full_busy", 32'(busy), 32'd1);
    force_full = 1'b0;
    drain("drain_full", 3000);

    send_line("W3G", 1'b1);
    send_line("R123", 1'b0);
    drain("drain_errors", 3000);

    // Partial line abandoned by the idle timeout, then a normal read.
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h31);
    repeat (60) @(negedge clk);
    #1;
    check("timeout_idle", 32'(busy), 32'd0);
    send_line("R05", 1'b0);
    drain("drain_timeout", 3000);

    // Reset in the middle of a read reply.
    base = n_push;
    send_line("R10", 1'b0);
    k = 0;
    while (n_push < base + 2 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("rst_wait_two_bytes", 32'(n_push - base), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    exp_tx.delete();
    repeat (20) @(negedge clk);
    #1;
    check("rst_no_more_push", n_push - base, 32'd2);
    send_line("R00", 1'b1);
    drain("drain_after_rst", 3000);

    // Randomized lines with random TX back-pressure.
    rand_full = 1'b1;
    repeat (40) begin
      rand_body(b);
      send_q(b, $urandom_range(0, 1) == 1);
    end
    drain("drain_random", 40000);
    rand_full = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
